// File: rtl/seq_tx.sv
// rtl/seq_tx.sv - serial code-sequence transmitter, MSB first, repeated frames with idle gaps
// Registered outputs; busy/done handshake for a sequencing controller.
module seq_tx #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [N-1:0]  i_incode,
  input  logic          i_start,
  input  logic [CW-1:0] i_nrep,
  input  logic [CW-1:0] i_gap,
  output logic          o_outbit,
  output logic          o_frame,
  output logic          o_busy,
  output logic          o_done
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [BW-1:0] BIDX_MSB = BW'(N - 1);

  logic [1:0]    r_state;
  logic [N-1:0]  r_code;
  logic [BW-1:0] r_bidx;
  logic [CW-1:0] r_frem;
  logic [CW-1:0] r_gcnt;
  logic [CW-1:0] r_glen;
  logic          r_outbit;
  logic          r_frame;
  logic          r_busy;
  logic          r_done;

  logic [N-1:0]  w_code_start;
  logic [BW-1:0] w_bidx_dec;
  logic [CW-1:0] w_frem_dec;

  // A load in the start cycle must already feed the first bit.
  assign w_code_start = i_load ? i_incode : r_code;
  assign w_bidx_dec   = r_bidx - BW'(1);
  assign w_frem_dec   = (r_frem != '0) ? (r_frem - CW'(1)) : r_frem;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_code   <= '0;
      r_bidx   <= '0;
      r_frem   <= '0;
      r_gcnt   <= '0;
      r_glen   <= '0;
      r_outbit <= 1'b0;
      r_frame  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_load) r_code <= i_incode;
          if (i_start) begin
            r_frem   <= (i_nrep == '0) ? CW'(1) : i_nrep;
            r_glen   <= i_gap;
            r_bidx   <= BIDX_MSB;
            r_state  <= S_SEND;
            r_outbit <= w_code_start[N-1];
            r_frame  <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_SEND: begin
          if (r_bidx == '0) begin
            r_frem <= w_frem_dec;
            if (w_frem_dec == '0) begin
              r_state  <= S_IDLE;
              r_outbit <= 1'b0;
              r_frame  <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else if (r_glen == '0) begin
              r_bidx   <= BIDX_MSB;
              r_outbit <= r_code[N-1];
            end else begin
              r_state  <= S_GAP;
              r_gcnt   <= r_glen;
              r_outbit <= 1'b0;
              r_frame  <= 1'b0;
            end
          end else begin
            r_bidx   <= w_bidx_dec;
            r_outbit <= r_code[w_bidx_dec];
          end
        end
        S_GAP: begin
          // gcnt holds the gap cycles still to spend, including the current one.
          if (r_gcnt <= CW'(1)) begin
            r_state  <= S_SEND;
            r_bidx   <= BIDX_MSB;
            r_outbit <= r_code[N-1];
            r_frame  <= 1'b1;
          end else begin
            r_gcnt <= r_gcnt - CW'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_outbit <= 1'b0;
          r_frame  <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_outbit = r_outbit;
  assign o_frame  = r_frame;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: doc/seq_tx.md
# seq_tx

Serial code-sequence transmitter: holds an N-bit code word and, on request, shifts it out one bit per clock, MSB first, as one or more frames separated by a programmable idle gap. It drives the serial input of the team's shift-register sequence detector. After each frame, a detector loaded with the same code and fed `outbit` raises its match output. A `busy`/`done` handshake lets a controller sequence transmissions.

## Interface
- `N`, 4, code word width in bits (≥2)
- `CW`, 4, width of repeat-count and gap-length fields
- `clk`  in  1  system clock, rising-edge active
- `rst`  in  1  reset, asynchronous, active-high
- `load`  in  1  capture `incode` into the code register (honoured only in IDLE)
- `incode`  in  N  code word to transmit
- `start`  in  1  begin a transmission (honoured only in IDLE)
- `nrep`  in  CW  number of frames; 0 is treated as 1
- `gap`  in  CW  idle cycles between consecutive frames; 0 means back-to-back
- `outbit`  out  1  serial data, registered
- `frame`  out  1  high on every cycle in which `outbit` carries a code bit
- `busy`  out  1  high from the first bit through the last bit of the transmission
- `done`  out  1  one-cycle pulse after the last bit of the transmission

## Operation
- State machine states: IDLE, SEND, GAP.
- Registers:
  - `code[N-1:0]`
  - bit index `bidx` (0..N-1)
  - frames-remaining counter `frem` (CW bits)
  - gap counter `gcnt` (CW bits)
  - latched gap length `glen`
- IDLE:
  - `load`=1: `code`←`incode`.
  - `start`=1: latch `frem`←max(`nrep`,1) and `glen`←`gap`; set `bidx`←N-1; go to SEND.
  - `load` and `start` in the same cycle: the frame uses the newly loaded `incode` value.
- SEND:
  - Each cycle drives `outbit`=`code[bidx]` and `frame`=1.
  - At `bidx`=0 the frame ends; `frem` decrements.
  - If `frem` becomes 0: go to IDLE and pulse `done`.
  - Else if `glen`=0: go straight to SEND with `bidx`←N-1.
  - Else: go to GAP with `gcnt`←`glen`.
  - Bit order is MSB first, so a detector that shifts into bit 0 holds `code` aligned after N shifts.
- GAP:
  - `outbit`=0, `frame`=0, `busy`=1.
  - `gcnt` decrements each cycle; when it reaches 1, the next cycle is SEND with `bidx`←N-1.
- `load` or `start` while not in IDLE: ignored, with no side effects. The transmission in flight and the code register are both unchanged.
- Counters never wrap: `frem` is only decremented while it is nonzero, and `gcnt` is only decremented while it is greater than 1.
- Outside SEND: `outbit`=0 and `frame`=0.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - `outbit`=0, `frame`=0, `busy`=0, `done`=0.
  - `code`=0, all counters 0, state IDLE.
  - A frame interrupted by reset is not resumed; no `done` is issued for it.
- Latency: `start` sampled at rising edge k puts the first bit (`code[N-1]`) on `outbit` during cycle k+1, with `frame`=`busy`=1.
- One frame occupies N cycles. The total transmission lasts F·N + (F−1)·`gap` cycles, where F = max(`nrep`,1).
- `busy` falls and `done` rises in the cycle right after the last bit (`code[0]`). `done` lasts exactly one cycle.
- A new `start` is accepted in the same cycle `done` is high, because the state is IDLE then. The next frame's first bit then directly follows the `done` cycle.
- `nrep` and `gap` are sampled only at start. Later changes have no effect on the transmission in flight.

## Test plan
- **Reset then single frame:** reset, `load` `incode`=4'b1011, then `start` with `nrep`=0 → `outbit` reads 1,0,1,1 on cycles k+1..k+4, `frame`/`busy` high on those cycles, `done` pulses at k+5. A detector loaded with 4'b1011 and fed `outbit` matches at k+5.
- **Repeat with gap:** code 4'b1100, `nrep`=3, `gap`=2 → 1100 00 1100 00 1100, 16 `busy` cycles, one `done` pulse, `frame` low during both gaps.
- **Back-to-back:** code 4'b0110, `nrep`=2, `gap`=0 → 01100110 with `frame` high on all 8 cycles, then `done`.
- **Ignored requests:** during a transmission, assert `load` with 4'b1111 and assert `start` → the current output is unchanged, `code` still holds the old value afterwards, and no extra frames are sent.
- **Simultaneous load+start and re-start on done:** `load`+`start` with `incode`=4'b1001 → 1001 is sent. Assert `start` in the `done` cycle → a second 1001 begins on the next cycle.
- **Async reset mid-frame:** assert `rst` between clock edges during bit 2 → all outputs go to 0 immediately with no `done` pulse. After release, the state is IDLE and `code`=0.
